// File: rtl/muldiv9900_defs.sv
// Shared op/state encodings for the multiply/divide unit and the CPU decode logic.
package muldiv9900_defs;

    localparam logic [1:0] OP_MPY  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MPYS = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        PREP = ST_PREP,
        RUN  = ST_RUN,
        POST = ST_POST,
        DONE = ST_DONE
    } state_t;

    // {logical-greater, arithmetic-greater, equal} of a signed value against zero
    function automatic logic [2:0] status_bits(input logic neg, input logic zero);
        return {~zero, ~neg & ~zero, zero};
    endfunction

endpackage

// File: rtl/muldiv9900_step.sv
// One iteration of the serial datapath: shift-add for multiply, restoring shift-subtract for divide.
module muldiv9900_step #(
    parameter int WIDTH = 16
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = rem + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {rem[WIDTH-1:0], lo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        if (is_div) begin
            // a borrow means the divisor did not fit: keep the shifted remainder
            rem_next = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
            lo_next  = {lo[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
            rem_next = {1'b0, sum[WIDTH:1]};
            lo_next  = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv9900.sv
// Serial multiply/divide unit: unsigned and signed, WIDTH x WIDTH -> 2*WIDTH and 2*WIDTH / WIDTH.
module muldiv9900
    import muldiv9900_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst_hi,
    input  logic [WIDTH-1:0] dst_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             ovf,
    output logic             st_lgt,
    output logic             st_agt,
    output logic             st_eq
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_reg, state_next;

    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   src_reg, dhi_reg, dlo_reg;
    logic [WIDTH-1:0]   opnd_reg, lo_reg;
    logic [WIDTH:0]     rem_reg;
    logic [CW-1:0]      cnt_reg;
    logic               qneg_reg, rneg_reg, povf_reg;

    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   lo_step;

    logic               src_neg, dhi_neg, div_uovf, quo_fits;
    logic [WIDTH-1:0]   src_mag, dhi_mag, quo_s, rem_s;
    logic [2*WIDTH-1:0] dvd, dvd_mag, prod, prod_s;

    muldiv9900_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_reg[0]),
        .rem      (rem_reg),
        .lo       (lo_reg),
        .opnd     (opnd_reg),
        .rem_next (rem_step),
        .lo_next  (lo_step)
    );

    always_comb begin
        src_neg  = op_reg[1] & src_reg[WIDTH-1];
        dhi_neg  = op_reg[1] & dhi_reg[WIDTH-1];
        src_mag  = src_neg ? -src_reg : src_reg;
        dhi_mag  = dhi_neg ? -dhi_reg : dhi_reg;
        dvd      = {dhi_reg, dlo_reg};
        dvd_mag  = dhi_reg[WIDTH-1] ? -dvd : dvd;
        div_uovf = (src_reg <= dhi_reg);
        prod     = {rem_reg[WIDTH-1:0], lo_reg};
        prod_s   = qneg_reg ? -prod : prod;
        quo_s    = qneg_reg ? -lo_reg : lo_reg;
        rem_s    = rneg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
        // a negative quotient may reach magnitude 2^(WIDTH-1), a positive one may not
        quo_fits = qneg_reg ? (lo_reg <= MIN_MAG) : ~lo_reg[WIDTH-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = PREP;
            PREP: begin
                busy       = 1'b1;
                state_next = (op_reg == OP_DIV && div_uovf) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) state_next = POST;
            end
            POST: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg    <= '0;
            src_reg   <= '0;
            dhi_reg   <= '0;
            dlo_reg   <= '0;
            opnd_reg  <= '0;
            lo_reg    <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            qneg_reg  <= 1'b0;
            rneg_reg  <= 1'b0;
            povf_reg  <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
            ovf       <= 1'b0;
            {st_lgt, st_agt, st_eq} <= 3'b000;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    op_reg  <= op;
                    src_reg <= src;
                    dhi_reg <= dst_hi;
                    dlo_reg <= dst_lo;
                end
                PREP: begin
                    cnt_reg  <= '0;
                    povf_reg <= 1'b0;
                    qneg_reg <= 1'b0;
                    rneg_reg <= 1'b0;
                    case (op_reg)
                        OP_MPY: begin
                            opnd_reg <= dhi_reg;
                            lo_reg   <= src_reg;
                            rem_reg  <= '0;
                        end
                        OP_MPYS: begin
                            opnd_reg <= dhi_mag;
                            lo_reg   <= src_mag;
                            rem_reg  <= '0;
                            qneg_reg <= dhi_neg ^ src_neg;
                        end
                        OP_DIV: begin
                            opnd_reg <= src_reg;
                            rem_reg  <= {1'b0, dhi_reg};
                            lo_reg   <= dlo_reg;
                            if (div_uovf) begin
                                result_hi <= dhi_reg;
                                result_lo <= dlo_reg;
                                ovf       <= 1'b1;
                                {st_lgt, st_agt, st_eq} <= 3'b000;
                            end
                        end
                        default: begin
                            opnd_reg <= src_mag;
                            rem_reg  <= {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
                            lo_reg   <= dvd_mag[WIDTH-1:0];
                            qneg_reg <= dhi_reg[WIDTH-1] ^ src_neg;
                            rneg_reg <= dhi_reg[WIDTH-1];
                            // high magnitude >= divisor means the quotient cannot fit in WIDTH bits
                            povf_reg <= (src_mag == '0) || (dvd_mag[2*WIDTH-1:WIDTH] >= src_mag);
                        end
                    endcase
                end
                RUN: begin
                    rem_reg <= rem_step;
                    lo_reg  <= lo_step;
                    cnt_reg <= cnt_reg + CW'(1);
                end
                POST: begin
                    ovf <= 1'b0;
                    {st_lgt, st_agt, st_eq} <= 3'b000;
                    case (op_reg)
                        OP_MPY: begin
                            result_hi <= rem_reg[WIDTH-1:0];
                            result_lo <= lo_reg;
                        end
                        OP_MPYS: begin
                            {result_hi, result_lo}  <= prod_s;
                            {st_lgt, st_agt, st_eq} <= status_bits(prod_s[2*WIDTH-1], prod_s == '0);
                        end
                        OP_DIV: begin
                            result_hi <= lo_reg;
                            result_lo <= rem_reg[WIDTH-1:0];
                        end
                        default: begin
                            if (povf_reg || !quo_fits) begin
                                result_hi <= dhi_reg;
                                result_lo <= dlo_reg;
                                ovf       <= 1'b1;
                            end else begin
                                result_hi <= quo_s;
                                result_lo <= rem_s;
                                {st_lgt, st_agt, st_eq} <= status_bits(quo_s[WIDTH-1], quo_s == '0);
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv9900.sv
// Self-checking bench for muldiv9900: vector table, random ops against a reference model, corner sequences.
module tb_muldiv9900;

    localparam int W = 16;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] src, dhi, dlo, ehi, elo;
        logic         eovf, elgt, eagt, eeq;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi, lo;
        logic         ovf, lgt, agt, eq;
        int           lat;
        int           acc;
        int           id;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src = '0, dst_hi = '0, dst_lo = '0;
    logic         busy, done, ovf, st_lgt, st_agt, st_eq;
    logic [W-1:0] result_hi, result_lo;

    int   ncmp = 0;
    int   nfail = 0;
    int   ndone = 0;
    int   cyc = 0;
    int   txn_id = 0;
    exp_t sb[$];
    vec_t tbl[16];

    muldiv9900 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src       (src),
        .dst_hi    (dst_hi),
        .dst_lo    (dst_lo),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .ovf       (ovf),
        .st_lgt    (st_lgt),
        .st_agt    (st_agt),
        .st_eq     (st_eq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference built on native integer arithmetic
    function automatic exp_t model(input logic [1:0] mop, input logic [W-1:0] s,
                                   input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t        e;
        longint      a, b, q, r, p;
        logic [31:0] u;
        e = '{hi: h, lo: l, ovf: 1'b0, lgt: 1'b0, agt: 1'b0, eq: 1'b0, lat: W + 2, acc: 0, id: 0};
        case (mop)
            2'b00: begin
                u = {16'h0, h} * {16'h0, s};
                e.hi = u[31:16];
                e.lo = u[15:0];
            end
            2'b10: begin
                p = longint'($signed(h)) * longint'($signed(s));
                u = p[31:0];
                e.hi = u[31:16];
                e.lo = u[15:0];
                e.lgt = (p != 0);
                e.agt = (p > 0);
                e.eq  = (p == 0);
            end
            2'b01: begin
                if (s <= h) begin
                    e.ovf = 1'b1;
                    e.lat = 1;
                end else begin
                    u = {h, l} / {16'h0, s};
                    e.hi = u[15:0];
                    u = {h, l} % {16'h0, s};
                    e.lo = u[15:0];
                end
            end
            default: begin
                a = longint'($signed({h, l}));
                b = longint'($signed(s));
                if (b == 0) begin
                    e.ovf = 1'b1;
                end else begin
                    q = a / b;
                    r = a % b;
                    if (q > 32767 || q < -32768) begin
                        e.ovf = 1'b1;
                    end else begin
                        e.hi  = q[15:0];
                        e.lo  = r[15:0];
                        e.lgt = (q != 0);
                        e.agt = (q > 0);
                        e.eq  = (q == 0);
                    end
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            int   lat;
            ndone = ndone + 1;
            ncmp  = ncmp + 1;
            if (sb.size() == 0) begin
                nfail = nfail + 1;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending op", cyc);
            end else begin
                e   = sb.pop_front();
                lat = cyc - e.acc;
                if (result_hi !== e.hi || result_lo !== e.lo || ovf !== e.ovf ||
                    {st_lgt, st_agt, st_eq} !== {e.lgt, e.agt, e.eq} || lat != e.lat) begin
                    nfail = nfail + 1;
                    $display("FAIL txn%0d: got hi=%h lo=%h ovf=%b st=%b%b%b lat=%0d, required hi=%h lo=%h ovf=%b st=%b%b%b lat=%0d",
                             e.id, result_hi, result_lo, ovf, st_lgt, st_agt, st_eq, lat,
                             e.hi, e.lo, e.ovf, e.lgt, e.agt, e.eq, e.lat);
                end else begin
                    $display("txn%0d ok: hi=%h lo=%h ovf=%b st=%b%b%b lat=%0d",
                             e.id, result_hi, result_lo, ovf, st_lgt, st_agt, st_eq, lat);
                end
            end
        end
    end

    // Call at a negedge; returns at a negedge with the scoreboard drained
    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            ncmp  = ncmp + 1;
            nfail = nfail + 1;
            $display("FAIL timeout: got no done within %0d cycles, required done", n);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] mop, input logic [W-1:0] s,
                         input logic [W-1:0] h, input logic [W-1:0] l, input exp_t e);
        op     = mop;
        src    = s;
        dst_hi = h;
        dst_lo = l;
        start  = 1'b1;
        e.acc  = cyc + 1;
        e.id   = txn_id;
        txn_id++;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero(input string name);
        ncmp = ncmp + 1;
        if ({busy, done, result_hi, result_lo, ovf, st_lgt, st_agt, st_eq} !== '0) begin
            nfail = nfail + 1;
            $display("FAIL %s: got busy=%b done=%b hi=%h lo=%h ovf=%b st=%b%b%b, required all zero",
                     name, busy, done, result_hi, result_lo, ovf, st_lgt, st_agt, st_eq);
        end else begin
            $display("%s ok: all outputs zero", name);
        end
    endtask

    initial begin
        exp_t         e;
        logic [1:0]   rop;
        logic [W-1:0] rs, rh, rl;
        int           nd0;
        bit           seen;

        //         op     src       dhi       dlo       ehi       elo       ovf   lgt   agt   eq    lat
        tbl[0]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 18};
        tbl[1]  = '{2'b01, 16'h0002, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 18};
        tbl[2]  = '{2'b01, 16'h0005, 16'h0005, 16'h1234, 16'h0005, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[3]  = '{2'b01, 16'h0000, 16'h0005, 16'h1234, 16'h0005, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[4]  = '{2'b10, 16'h0003, 16'hFFFE, 16'h0000, 16'hFFFF, 16'hFFFA, 1'b0, 1'b1, 1'b0, 1'b0, 18};
        tbl[5]  = '{2'b11, 16'h0002, 16'hFFFF, 16'hFFF9, 16'hFFFD, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 18};
        tbl[6]  = '{2'b11, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 18};
        tbl[7]  = '{2'b00, 16'h0101, 16'h00FF, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 18};
        tbl[8]  = '{2'b10, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 18};
        tbl[9]  = '{2'b10, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 18};
        tbl[10] = '{2'b11, 16'h0000, 16'h0000, 16'h0064, 16'h0000, 16'h0064, 1'b1, 1'b0, 1'b0, 1'b0, 18};
        tbl[11] = '{2'b11, 16'hFFF9, 16'h0000, 16'h0064, 16'hFFF2, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 18};
        tbl[12] = '{2'b11, 16'h0001, 16'hFFFF, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 18};
        tbl[13] = '{2'b11, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 18};
        tbl[14] = '{2'b01, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 18};
        tbl[15] = '{2'b11, 16'h0002, 16'h0000, 16'h0007, 16'h0003, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 18};

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;

        // first op starts on the very first edge after reset release
        for (int i = 0; i < 16; i++) begin
            e = '{hi: tbl[i].ehi, lo: tbl[i].elo, ovf: tbl[i].eovf, lgt: tbl[i].elgt,
                  agt: tbl[i].eagt, eq: tbl[i].eeq, lat: tbl[i].lat, acc: 0, id: 0};
            drive(tbl[i].op, tbl[i].src, tbl[i].dhi, tbl[i].dlo, e);
            wait_empty();
        end

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            rs  = 16'($urandom);
            rh  = 16'($urandom);
            rl  = 16'($urandom);
            if (rop == 2'b01 && $urandom_range(0, 3) != 0) rh = rs >> $urandom_range(1, 8);
            if (rop == 2'b11 && $urandom_range(0, 2) != 0) rh = {16{rl[15]}};
            drive(rop, rs, rh, rl, model(rop, rs, rh, rl));
            wait_empty();
        end

        // start held high through busy and the done cycle must be ignored
        nd0 = ndone;
        e = '{hi: 16'h0001, lo: 16'h2340, ovf: 1'b0, lgt: 1'b0, agt: 1'b0, eq: 1'b0, lat: 18, acc: 0, id: 0};
        drive(2'b00, 16'h0010, 16'h1234, 16'h0000, e);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            op     = 2'($urandom_range(0, 3));
            src    = 16'($urandom);
            dst_hi = 16'($urandom);
            start  = 1'b1;
            @(negedge clk);
            seen = done;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        ncmp = ncmp + 1;
        if (!seen || ndone - nd0 != 1 || result_hi !== 16'h0001 || result_lo !== 16'h2340) begin
            nfail = nfail + 1;
            $display("FAIL start_during_busy: got %0d done pulses hi=%h lo=%h, required 1 pulse hi=0001 lo=2340",
                     ndone - nd0, result_hi, result_lo);
        end else begin
            $display("start_during_busy ok: 1 done pulse, results held");
        end
        sb.delete();

        // asynchronous reset in the middle of a multiply
        op     = 2'b00;
        src    = 16'h00FF;
        dst_hi = 16'h0F0F;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_zero("mid_op_reset");
        @(negedge clk);
        reset = 1'b0;
        drive(2'b10, 16'h0007, 16'hFFF0, 16'h0000, model(2'b10, 16'h0007, 16'hFFF0, 16'h0000));
        wait_empty();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/muldiv9900.md
MULDIV9900 -- requirements
Module: muldiv9900

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand word width (WIDTH >= 4, even).
REQ-002 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0 and done=0.
REQ-005 SHALL have port op  input  2  operation select: 00 MPY, 01 DIV, 10 MPYS, 11 DIVS.
REQ-006 SHALL have port src  input  WIDTH  multiplier or divisor, captured at start.
REQ-007 SHALL have port dst_hi  input  WIDTH  MPY/MPYS multiplicand, or DIV/DIVS dividend high word, captured at start.
REQ-008 SHALL have port dst_lo  input  WIDTH  DIV/DIVS dividend low word, captured at start; ignored for MPY/MPYS.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result_hi  output  WIDTH  product high word, or quotient.
REQ-012 SHALL have port result_lo  output  WIDTH  product low word, or remainder.
REQ-013 SHALL have ports ovf, st_lgt, st_agt, st_eq  output  1 each  overflow, logical-greater, arithmetic-greater and equal status.

Function
REQ-014 The state machine SHALL have the states IDLE, PREP, RUN, POST and DONE; start=1 in IDLE SHALL capture all operands and op and move to PREP.
REQ-015 PREP SHALL take the operand magnitudes (signed ops) and perform the DIV overflow check, then move to RUN; for an unsigned DIV overflow it SHALL go directly to DONE.
REQ-016 RUN SHALL last exactly WIDTH cycles, performing one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, with a WIDTH+1-bit partial remainder.
REQ-017 POST SHALL apply the sign correction and the signed-overflow check; DONE SHALL last one cycle and then return to IDLE.
REQ-018 busy SHALL be 1 in PREP, RUN and POST and 0 otherwise; done SHALL be 1 only in DONE.
REQ-019 Latency: with start accepted at edge k, done SHALL be high in cycle k+WIDTH+3; for an unsigned DIV overflow, done SHALL be high in cycle k+2.
REQ-020 MPY SHALL produce the unsigned 2*WIDTH product, and MPYS the two's-complement 2*WIDTH product; ovf SHALL be 0 for both.
REQ-021 DIV SHALL set ovf=1 when src <= dst_hi (unsigned), which includes src=0; in that case result_hi=dst_hi and result_lo=dst_lo (unchanged).
REQ-022 DIVS SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-023 DIVS SHALL set ovf=1, leaving results = dst_hi/dst_lo, when src=0 or the quotient lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-024 For MPYS, st_lgt/st_agt/st_eq SHALL reflect the 2*WIDTH result compared with 0: st_lgt = nonzero, st_agt = positive and nonzero, st_eq = zero.
REQ-025 For DIVS without overflow, st_lgt/st_agt/st_eq SHALL use the same rules applied to the quotient.
REQ-026 For MPY, DIV, or any overflow, st_lgt, st_agt and st_eq SHALL be 0.
REQ-027 All results and status outputs SHALL become valid in the done cycle and hold until the next accepted start.
REQ-028 start while busy=1 or done=1 SHALL be ignored, with no effect on the operation in flight.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, busy=0, done=0, result_hi=0, result_lo=0, ovf=0 and all status outputs to 0, including mid-operation.
REQ-030 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-031 The op encodings and state encodings SHALL be localparams in a shared include, muldiv9900_defs, which is also used by the CPU decode logic.
REQ-032 The per-cycle combinational add/subtract step SHALL be one sub-module, muldiv9900_step, parametrised by WIDTH.
REQ-033 The block SHALL contain no other sub-modules and no memories.

Verification
REQ-034 MPY with dst_hi=0xFFFF, src=0xFFFF: result_hi=0xFFFE, result_lo=0x0001, ovf=0, done exactly 19 cycles after start.
REQ-035 DIV with dividend 0x0001_0000 and src=0x0002: result_hi=0x8000, result_lo=0x0000, ovf=0.
REQ-036 DIV with dst_hi=0x0005, dst_lo=0x1234, src=0x0005: ovf=1, results 0x0005/0x1234, done 2 cycles after start; the same holds for src=0.
REQ-037 MPYS with dst_hi=0xFFFE, src=0x0003: result 0xFFFF_FFFA, st_lgt=1, st_agt=0, st_eq=0.
REQ-038 DIVS with dividend 0xFFFF_FFF9 (-7), src=0x0002: result_hi=0xFFFD, result_lo=0xFFFF; a dividend of 0x0001_0000 with src=1 gives ovf=1.
REQ-039 reset asserted 5 cycles into an MPY gives busy=0, done=0 and all outputs 0 at once; a start asserted during busy produces exactly one done pulse.
